// File: rtl/mips_store_buffer.sv
// mips_store_buffer: posted-write FIFO between a MIPS core and a shared memory port.
// Loads own the port and bypass buffered stores. The load-hazard policy is chosen by the
// STORE_BUF_FWD_EN macro: when defined, loads are forwarded from matching stores; when
// undefined, a matching load stalls until the matching stores have drained.
// Ports:
//   clk, rst (async, active-low)
//   CPU side: en, cpu_write_en[3:0], cpu_read_en, cpu_addr, cpu_write_data,
//             cpu_read_data, stall
//   Memory side: mem_write_en[3:0], mem_read_en, mem_addr, mem_write_data,
//                mem_read_data, mem_ready
//   Status: empty
// Byte lane k of a data word is enabled by mask bit k.
// Mask bit 3 (data[31:24]) is the byte at address offset 0.
module mips_store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [3:0]  cpu_write_en,
  input  logic        cpu_read_en,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_write_data,
  output logic [31:0] cpu_read_data,
  output logic        stall,
  output logic [3:0]  mem_write_en,
  output logic        mem_read_en,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data,
  input  logic        mem_ready,
  output logic        empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [29:0]      r_addr  [DEPTH];
  logic [3:0]       r_mask  [DEPTH];
  logic [31:0]      r_data  [DEPTH];
  logic [DEPTH-1:0] r_valid;
  logic [PW-1:0]    r_head;
  logic [PW-1:0]    r_tail;
  logic [CW-1:0]    r_count;

  logic             r_rd_pend;
  logic [3:0]       r_fwd_mask;
  logic [31:0]      r_fwd_data;
  logic [31:0]      r_rd_hold;

  logic             w_store;
  logic             w_load;
  logic             w_full;
  logic             w_match;
  logic             w_hazard;
  logic             w_issue;
  logic             w_drain;
  logic             w_pop;
  logic             w_push;
  logic             w_accept;
  logic [3:0]       w_fwd_mask;
  logic [31:0]      w_fwd_data;
  logic [31:0]      w_rd_merge;

  // Requests are masked during reset so the outputs read idle.
  assign w_store = rst & en & (|cpu_write_en);
  assign w_load  = rst & en & cpu_read_en;
  assign w_full  = (r_count == CW'(DEPTH));

  always_comb begin
    w_match = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_valid[i] && (r_addr[i] == cpu_addr[31:2])) begin
        w_match = 1'b1;
      end
    end
  end

`ifdef STORE_BUF_FWD_EN
  // Walk oldest to youngest so the youngest writer of each byte wins.
  always_comb begin
    logic [PW-1:0] idx;
    w_fwd_mask = '0;
    w_fwd_data = '0;
    idx        = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = r_head + PW'(k);
      if ((CW'(k) < r_count) && r_valid[idx] &&
          (r_addr[idx] == cpu_addr[31:2])) begin
        for (int b = 0; b < 4; b++) begin
          if (r_mask[idx][b]) begin
            w_fwd_mask[b]        = 1'b1;
            w_fwd_data[8*b +: 8] = r_data[idx][8*b +: 8];
          end
        end
      end
    end
  end
  assign w_hazard = 1'b0;
`else
  assign w_fwd_mask = '0;
  assign w_fwd_data = '0;
  assign w_hazard   = w_match;
`endif

  // A hazarded load is held off the port so the buffer can drain past it.
  assign w_issue = w_load & ~w_hazard;
  assign w_drain = ~w_issue & (r_count != '0);
  assign w_pop   = w_drain & mem_ready;

  assign stall = (w_load & (w_hazard | ~mem_ready)) |
                 (w_store & w_full & ~w_pop);

  assign w_push   = w_store & ~stall;
  assign w_accept = w_load & ~stall;

  always_comb begin
    mem_write_en   = '0;
    mem_read_en    = 1'b0;
    mem_addr       = '0;
    mem_write_data = '0;
    if (w_issue) begin
      mem_read_en = 1'b1;
      mem_addr    = cpu_addr & 32'hFFFF_FFFC;
    end else if (w_drain) begin
      mem_write_en   = r_mask[r_head];
      mem_addr       = {r_addr[r_head], 2'b00};
      mem_write_data = r_data[r_head];
    end
  end

  assign empty = (r_count == '0);

  always_comb begin
    for (int b = 0; b < 4; b++) begin
      w_rd_merge[8*b +: 8] = r_fwd_mask[b] ? r_fwd_data[8*b +: 8]
                                           : mem_read_data[8*b +: 8];
    end
  end

  // Memory data only arrives in the cycle after acceptance, so the
  // merged word is shown live then and held in r_rd_hold afterwards.
  assign cpu_read_data = r_rd_pend ? w_rd_merge : r_rd_hold;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_valid <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_addr[i] <= '0;
        r_mask[i] <= '0;
        r_data[i] <= '0;
      end
    end else begin
      // When full, push and pop hit the same slot; the push wins.
      if (w_pop) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + 1'b1;
      end
      if (w_push) begin
        r_valid[r_tail] <= 1'b1;
        r_addr[r_tail]  <= cpu_addr[31:2];
        r_mask[r_tail]  <= cpu_write_en;
        r_data[r_tail]  <= cpu_write_data;
        r_tail          <= r_tail + 1'b1;
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_pend  <= 1'b0;
      r_fwd_mask <= '0;
      r_fwd_data <= '0;
      r_rd_hold  <= '0;
    end else begin
      r_rd_pend <= w_accept;
      if (w_accept) begin
        r_fwd_mask <= w_fwd_mask;
        r_fwd_data <= w_fwd_data;
      end
      if (r_rd_pend) begin
        r_rd_hold <= w_rd_merge;
      end
    end
  end

endmodule
